// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Parity modes, transmit FSM states and the minimum divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    EVEN     = 2'b01,
    ODD      = 2'b10,
    NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_tx_frame_fifo.sv
// Synchronous FIFO with occupancy count.
// Overflowing pushes and underflowing pops are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers and count; both ends may move on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: FIFO, runtime divisor, parity, 1/2 stop.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        in_valid,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_busy,
  output logic                        txd
);

  localparam int BW = $clog2(DATA_BITS + 1);

  tx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 pen_q, pen_d;
  logic                 stop2_q, stop2_d;
  logic                 stopn_q, stopn_d;
  logic                 line;
  logic                 tick;
  logic                 load;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] pop_data;
  parity_e              par_cfg;

  assign par_cfg  = parity_e'(cfg_parity);
  assign tick     = (cnt_q == '0);
  assign in_ready = !reset && !full;
  assign div_eff  = (cfg_div < DIV_WIDTH'(MIN_DIV))
                  ? DIV_WIDTH'(MIN_DIV) : cfg_div;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Next-state, bit timing and line level for the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pen_d   = pen_q;
    stop2_d = stop2_q;
    stopn_d = stopn_q;
    line    = 1'b1;
    load    = 1'b0;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = tick ? div_q - DIV_WIDTH'(1)
                   : cnt_q - DIV_WIDTH'(1);
    end
    unique case (state_q)
      IDLE: begin
        load = !empty;
      end
      START: begin
        line = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        line = sh_q[0];
        if (tick) begin
          sh_d  = sh_q >> 1;
          par_d = par_q ^ sh_q[0];
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = pen_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        line = par_q;
        if (tick) state_d = STOP;
      end
      STOP: begin
        line = 1'b1;
        if (tick) begin
          if (stop2_q && !stopn_q) begin
            stopn_d = 1'b1;
          end else begin
            state_d = IDLE;
            load    = !empty;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = div_eff - DIV_WIDTH'(1);
      div_d   = div_eff;
      bit_d   = '0;
      sh_d    = pop_data;
      par_d   = (par_cfg == ODD);
      pen_d   = (par_cfg == EVEN) || (par_cfg == ODD);
      stop2_d = cfg_stop2;
      stopn_d = 1'b0;
    end
  end

  // Frame state and registered line outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(MIN_DIV);
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      stop2_q <= 1'b0;
      stopn_q <= 1'b0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      stop2_q <= stop2_d;
      stopn_q <= stopn_d;
      txd     <= line;
      tx_busy <= (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised bench for uart_tx_frame against a per-clock line model.
// A second 5-bit instance checks a short-frame case.
module tb_uart_tx_frame;

  logic        clock;
  logic        reset;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [4:0]  fifo_count;
  logic        tx_busy;
  logic        txd;

  logic [15:0] div5;
  logic [1:0]  par5;
  logic        stop5;
  logic        valid5;
  logic [4:0]  data5;
  logic        ready5;
  logic [4:0]  count5;
  logic        busy5;
  logic        txd5;

  int n_tests;
  int n_fail;

  bit [7:0] mq[$];
  bit       fq[$];
  bit       xq[$];
  bit       cur_line;
  bit       cur_busy;
  bit       exp_txd;
  bit       exp_busy;

  uart_tx_frame dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .txd        (txd)
  );

  uart_tx_frame #(
    .DATA_BITS (5)
  ) dut5 (
    .clock      (clock),
    .reset      (reset),
    .cfg_div    (div5),
    .cfg_parity (par5),
    .cfg_stop2  (stop5),
    .in_valid   (valid5),
    .in_data    (data5),
    .in_ready   (ready5),
    .fifo_count (count5),
    .tx_busy    (busy5),
    .txd        (txd5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Per-clock line levels of one whole frame, into xq.
  task automatic build_frame(input logic [8:0] d,
                             input int db,
                             input int div,
                             input logic [1:0] par,
                             input logic s2);
    bit b[$];
    bit p;
    int dv;
    dv = (div < 2) ? 2 : div;
    p = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      b.push_back(d[i]);
      p ^= d[i];
    end
    if (par == 2'd1) b.push_back(p);
    if (par == 2'd2) b.push_back(~p);
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    xq.delete();
    foreach (b[i]) repeat (dv) xq.push_back(b[i]);
  endtask

  // One clock edge of the reference: queue of bytes plus line schedule.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    exp_txd  = cur_line;
    exp_busy = cur_busy;
    if (reset) begin
      mq.delete();
      fq.delete();
      cur_line = 1'b1;
      cur_busy = 1'b0;
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
      return;
    end
    do_pop  = (fq.size() <= 1) && (mq.size() > 0);
    do_push = in_valid && (mq.size() < 16);
    if (do_pop) begin
      build_frame({1'b0, mq.pop_front()}, 8, int'(cfg_div),
                  cfg_parity, cfg_stop2);
      fq = xq;
    end else if (fq.size() > 0) begin
      void'(fq.pop_front());
    end
    if (do_push) mq.push_back(in_data);
    cur_line = (fq.size() > 0) ? fq[0] : 1'b1;
    cur_busy = (fq.size() > 0);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("txd", 32'(txd), 32'(exp_txd));
    check("busy", 32'(tx_busy), 32'(exp_busy));
    check("count", 32'(fifo_count), 32'(mq.size()));
    check("ready", 32'(in_ready),
          32'(!reset && (mq.size() < 16)));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    int nb;
    int maxc;
    bit e;
    n_tests    = 0;
    n_fail     = 0;
    cur_line   = 1'b1;
    cur_busy   = 1'b0;
    exp_txd    = 1'b1;
    exp_busy   = 1'b0;
    reset      = 1'b1;
    cfg_div    = 16'd4;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    div5       = 16'd3;
    par5       = 2'd0;
    stop5      = 1'b0;
    valid5     = 1'b0;
    data5      = '0;
    run(3);
    reset = 1'b0;

    send(8'hA5);
    nb = 0;
    repeat (50) begin
      cycle();
      nb += int'(tx_busy);
    end
    check("busy_len", 32'(nb), 32'd40);

    cfg_div    = 16'd3;
    cfg_parity = 2'd1;
    cfg_stop2  = 1'b1;
    send(8'h07);
    run(45);
    cfg_parity = 2'd2;
    send(8'h07);
    run(45);

    cfg_div    = 16'd2;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      cycle();
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    in_valid = 1'b0;
    check("burst_max", 32'(maxc), 32'd16);
    run(400);

    cfg_div = 16'd0;
    send(8'h5A);
    run(30);

    cfg_div = 16'd4;
    send(8'h3C);
    send(8'hC3);
    run(10);
    cfg_div = 16'd8;
    run(150);

    cfg_div = 16'd4;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    run(12);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    run(100);

    repeat (2000) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_div    = 16'($urandom_range(0, 5));
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
      end
      in_valid = ($urandom_range(0, 9) < 3);
      in_data  = 8'($urandom);
      reset    = ($urandom_range(0, 799) == 0);
      cycle();
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    run(1200);

    valid5 = 1'b1;
    data5  = 5'h1F;
    cycle();
    valid5 = 1'b0;
    build_frame(9'h01F, 5, 3, 2'd0, 1'b0);
    for (int k = 0; k < 28; k++) begin
      cycle();
      e = (k >= 1 && k <= xq.size()) ? xq[k-1] : 1'b1;
      check("txd5", 32'(txd5), 32'(e));
      check("busy5", 32'(busy5),
            32'(k >= 1 && k <= xq.size()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with an input FIFO, runtime baud divisor, selectable parity and one or two stop bits. It replaces the fixed 8N1 single-byte transmitter in the host-link path: the core pushes bytes through a valid/ready port and the block serialises them back-to-back onto `txd` without per-byte handshaking.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5..9.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, at least 2.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `cfg_div` input DIV_WIDTH: clocks per bit; values 0 and 1 behave as 2.
- `cfg_parity` input 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` input 1: 1 selects two stop bits, 0 selects one.
- `in_valid` input 1: write request.
- `in_data` input DATA_BITS: payload, transmitted LSB first.
- `in_ready` output 1: FIFO not full.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: occupied entries.
- `tx_busy` output 1: a frame is in progress.
- `txd` output 1: serial line, idle high.

## Operation
- Write: the FIFO accepts `in_data` on any edge where `in_valid && in_ready`. `in_ready` is `!full`. A write while full is ignored and never corrupts the FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `txd`=1. When the FIFO is non-empty:
  - pop one entry;
  - latch `cfg_div`, `cfg_parity` and `cfg_stop2` into frame registers;
  - go to START.
- Configuration changes mid-frame do not affect the current frame.
- START: `txd`=0 for one bit time, then go to DATA.
- DATA: send DATA_BITS bits LSB first, one bit time each. After the last bit, go to PARITY if parity is enabled, else go to STOP.
- PARITY: send one bit.
  - Even: XOR of the data bits.
  - Odd: the inverse of that XOR.
- STOP: `txd`=1 for one bit time, or two if stop2 is latched. At the end of STOP:
  - if the FIFO is non-empty, pop and go directly to START with no idle gap;
  - otherwise go to IDLE.
- Bit time is exactly max(cfg_div,2) clocks, counted by a down-counter reloaded at every bit boundary. There is no cumulative drift.
- `tx_busy` is 1 in every state except IDLE.
- Push and pop on the same edge: `fifo_count` is unchanged and both take effect.
- Pointers wrap modulo FIFO_DEPTH. Full when count == FIFO_DEPTH; empty when count == 0.

## Timing
- During reset and after it:
  - `txd`=1, `tx_busy`=0, `fifo_count`=0;
  - FSM in IDLE, FIFO emptied;
  - `in_ready`=0 while `reset` is high and 1 on the first cycle after.
- Reset mid-frame aborts the frame: `txd` is 1 on the cycle after the reset edge.
- Latency into an empty idle block:
  - write accepted at edge E;
  - pop at edge E+1;
  - `txd`=0 and `tx_busy`=1 from edge E+2.
- Frame length in clocks is div × (1 + DATA_BITS + P + S), where P is 0 or 1 and S is 1 or 2.
- All outputs are registered except `in_ready`, which is decoded from the registered count.

## Structure
- Package `uart_pkg` holds:
  - `parity_e` enum: NONE, EVEN, ODD, NONE_ALT;
  - `tx_state_e` enum with the five states;
  - constant `MIN_DIV` = 2.
- Sub-module `sync_fifo`, parametrised by WIDTH and DEPTH, with push/pop/full/empty/count and registered storage. The FSM, bit counter, shift register and parity accumulator stay in the top module.

## Test plan
- 8N1, `cfg_div`=4, write 8'hA5 → `txd` low 4 clocks from E+2, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks; `tx_busy` high for 40 clocks.
- Even parity, two stop bits, `cfg_div`=3, data 8'h07 → parity bit 1, stop high for 6 clocks, frame 36 clocks. Same data with odd parity → parity bit 0.
- Burst of 17 writes with DEPTH 16 while the line is busy → `in_ready` drops at count 16, the 17th write is held, all accepted bytes go out back-to-back with no idle cycle between a stop bit and the next start bit.
- `cfg_div`=0 → bit time is 2 clocks. Changing `cfg_div` from 4 to 8 mid-frame → current frame keeps 4-clock bits and the next frame uses 8.
- Reset asserted in the DATA state with 3 bytes queued → `txd`=1 and `tx_busy`=0 on the next cycle, `fifo_count`=0, no further frames.
- DATA_BITS=5, data 5'h1F, no parity → 7-bit frame, tail line stays high.
